// File: rtl/mux_nto1_xor_pipe_pkg.sv
// Shared definitions for the N:1 XOR-invert pipelined mux.
//   MODE_FIXED / MODE_RR : values of the mode input
//   ST_EMPTY / ST_FULL   : output register occupancy encoding
//   next_idx(idx, n)     : wrap-around increment of a channel index
package mux_xor_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    function automatic int next_idx(input int idx, input int n);
        int r;
        if (idx >= n - 32'sd1) begin
            r = 32'sd0;
        end else begin
            r = idx + 32'sd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_nto1_xor_pipe_if.sv
// Bus bundle for mux_nto1_xor_pipe.
//   in_data/in_valid/in_ready : NUM_CH producer channels (ch k at [k*WIDTH +: WIDTH])
//   mode/sel/inv              : arbitration mode, fixed channel select, invert enable
//   out_data/out_ch/out_valid/out_ready : single registered consumer port
//   out_parity                : even parity of out_data (only with PARITY_EN)
// Modports: master = producer/consumer side, slave = the mux.
interface mux_nto1_xor_pipe_if #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4
);
    localparam int SELW = $clog2(NUM_CH);

    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       in_ready;
    logic                    mode;
    logic [SELW-1:0]         sel;
    logic                    inv;
    logic [WIDTH-1:0]        out_data;
    logic [SELW-1:0]         out_ch;
    logic                    out_valid;
    logic                    out_ready;
`ifdef PARITY_EN
    logic                    out_parity;
`endif

    modport master (
        output in_data, in_valid, mode, sel, inv, out_ready,
        input  in_ready, out_data, out_ch, out_valid
`ifdef PARITY_EN
        , input out_parity
`endif
    );

    modport slave (
        input  in_data, in_valid, mode, sel, inv, out_ready,
        output in_ready, out_data, out_ch, out_valid
`ifdef PARITY_EN
        , output out_parity
`endif
    );

endinterface

// File: rtl/mux_nto1_xor_pipe_rr_arbiter.sv
// Combinational round-robin arbiter.
//   i_req       : per-channel request vector
//   i_ptr       : channel with highest priority this cycle
//   o_grant     : index of first requesting channel at or after i_ptr (wrapping)
//   o_grant_vld : 1 when any channel requests
module rr_arbiter
    import mux_xor_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int SELW   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [SELW-1:0]   i_ptr,
    output logic [SELW-1:0]   o_grant,
    output logic              o_grant_vld
);

    int w_idx;

    // Walk channels from the pointer, wrapping, and take the first request.
    always_comb begin
        o_grant     = {SELW{1'b0}};
        o_grant_vld = 1'b0;
        w_idx       = int'(i_ptr);
        for (int i = 0; i < NUM_CH; i++) begin
            if (!o_grant_vld && (w_idx < NUM_CH) && i_req[w_idx]) begin
                o_grant     = SELW'(w_idx);
                o_grant_vld = 1'b1;
            end else begin
                o_grant_vld = o_grant_vld;
            end
            w_idx = next_idx(w_idx, NUM_CH);
        end
    end

endmodule

// File: rtl/mux_nto1_xor_pipe.sv
// Registered N:1 channel mux with conditional XOR inversion.
// Selects one of NUM_CH valid/ready channels (fixed select or round-robin),
// optionally inverts it, and holds it in a one-entry output register.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mux_nto1_xor_pipe_if.slave (inputs, per-channel ready, output port)
// Optional build macro PARITY_EN adds bus.out_parity = ^out_data, registered with it.
module mux_nto1_xor_pipe
    import mux_xor_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mux_nto1_xor_pipe_if.slave    bus
);
    localparam int SELW = $clog2(NUM_CH);

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_out_data;
    logic [SELW-1:0]  r_out_ch;
    logic [SELW-1:0]  r_rr_ptr;

    logic [SELW-1:0]  w_rr_grant;
    logic             w_rr_vld;
    logic [SELW-1:0]  w_grant;
    logic             w_grant_vld;
    logic             w_can_load;
    logic             w_xfer;
    logic [WIDTH-1:0] w_sel_data;
    logic [WIDTH-1:0] w_xor_data;
    logic [NUM_CH-1:0] w_in_ready;

`ifdef PARITY_EN
    logic r_out_parity;

    function automatic logic calc_parity(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction
`endif

    rr_arbiter #(.NUM_CH(NUM_CH), .SELW(SELW)) u_rr_arbiter (
        .i_req       (bus.in_valid),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_rr_grant),
        .o_grant_vld (w_rr_vld)
    );

    // Grant selection; fixed mode grants sel even without valid so in_ready tracks it.
    always_comb begin
        if (bus.mode == MODE_RR) begin
            w_grant     = w_rr_grant;
            w_grant_vld = w_rr_vld;
        end else begin
            w_grant     = bus.sel;
            w_grant_vld = (int'(bus.sel) < NUM_CH);
        end
    end

    // Handshake, data select and inversion; ready is forced low while in reset.
    always_comb begin
        w_can_load = (r_state == ST_EMPTY) || bus.out_ready;
        w_in_ready = {NUM_CH{1'b0}};
        w_sel_data = {WIDTH{1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_grant_vld && (w_grant == SELW'(k))) begin
                w_in_ready[k] = w_can_load && rst_n;
                w_sel_data    = bus.in_data[k*WIDTH +: WIDTH];
            end else begin
                w_in_ready[k] = 1'b0;
            end
        end
        w_xfer     = |(w_in_ready & bus.in_valid);
        w_xor_data = w_sel_data ^ {WIDTH{bus.inv}};
    end

    // Output register, occupancy state and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_EMPTY;
            r_out_data <= {WIDTH{1'b0}};
            r_out_ch   <= {SELW{1'b0}};
            r_rr_ptr   <= {SELW{1'b0}};
`ifdef PARITY_EN
            r_out_parity <= 1'b0;
`endif
        end else if (w_xfer) begin
            r_state    <= ST_FULL;
            r_out_data <= w_xor_data;
            r_out_ch   <= w_grant;
`ifdef PARITY_EN
            r_out_parity <= calc_parity(w_xor_data);
`endif
            if (bus.mode == MODE_RR) begin
                r_rr_ptr <= SELW'(next_idx(int'(w_grant), NUM_CH));
            end else begin
                r_rr_ptr <= r_rr_ptr;
            end
        end else if (bus.out_ready) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= r_state;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_out_data;
    assign bus.out_ch    = r_out_ch;
    assign bus.out_valid = (r_state == ST_FULL);
`ifdef PARITY_EN
    assign bus.out_parity = r_out_parity;
`endif

endmodule
